// File: rtl/p1_sweep_ctrl.sv
// Exhaustive self-test sequencer for a 4-input combinational unit: steps all 16
// input vectors, samples f after a settle time and accumulates mismatch results.
module p1_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [15:0] EXPECTED      = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        f_in,
   output logic [3:0]  abcd,
   output logic [3:0]  vec_idx,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] result,
   output logic [15:0] fail_mask,
   output logic [4:0]  err_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

   function automatic logic sample_miss(input logic f, input logic [15:0] tbl, input logic [3:0] idx);
      return f != tbl[idx];
   endfunction

   state_t      state_r, state_s;
   logic [7:0]  cnt_r, cnt_s;
   logic [3:0]  vec_r, vec_s;
   logic        busy_r, busy_s;
   logic        done_r, done_s;
   logic        pass_r, pass_s;
   logic [15:0] result_r, result_s;
   logic [15:0] fail_r, fail_s;
   logic [4:0]  err_r, err_s;

   // Next-state and next-output computation for the sweep FSM.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      vec_s    = vec_r;
      busy_s   = busy_r;
      done_s   = done_r;
      pass_s   = pass_r;
      result_s = result_r;
      fail_s   = fail_r;
      err_s    = err_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s  = ST_RUN;
               cnt_s    = 8'd0;
               vec_s    = 4'd0;
               busy_s   = 1'b1;
               done_s   = 1'b0;
               pass_s   = 1'b0;
               result_s = 16'h0000;
               fail_s   = 16'h0000;
               err_s    = 5'd0;
            end else begin
               state_s = state_r;
            end
         end
         ST_RUN: begin
            // abort outranks the sampling step on the same edge
            if (abort) begin
               state_s = ST_IDLE;
               cnt_s   = 8'd0;
               vec_s   = 4'd0;
               busy_s  = 1'b0;
               done_s  = 1'b0;
               pass_s  = 1'b0;
            end else if (cnt_r != LAST_CNT) begin
               cnt_s = cnt_r + 8'd1;
            end else begin
               result_s[vec_r] = f_in;
               if (sample_miss(f_in, EXPECTED, vec_r)) begin
                  fail_s[vec_r] = 1'b1;
                  err_s         = err_r + 5'd1;
               end else begin
                  err_s = err_r;
               end
               cnt_s = 8'd0;
               if (vec_r != 4'd15) begin
                  vec_s = vec_r + 4'd1;
               end else begin
                  state_s = ST_DONE;
                  vec_s   = 4'd0;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
                  pass_s  = (err_s == 5'd0);
               end
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 8'd0;
            vec_s   = 4'd0;
            busy_s  = 1'b0;
            done_s  = 1'b0;
            pass_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         cnt_r    <= 8'd0;
         vec_r    <= 4'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         pass_r   <= 1'b0;
         result_r <= 16'h0000;
         fail_r   <= 16'h0000;
         err_r    <= 5'd0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         vec_r    <= vec_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
         pass_r   <= pass_s;
         result_r <= result_s;
         fail_r   <= fail_s;
         err_r    <= err_s;
      end
   end

   assign abcd      = vec_r;
   assign vec_idx   = vec_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign result    = result_r;
   assign fail_mask = fail_r;
   assign err_count = err_r;

endmodule

// File: tb/tb_p1_sweep_ctrl.sv
// Scoreboard bench for p1_sweep_ctrl: two instances (settle 2 and settle 1) driven
// by randomized truth tables; a monitor checks vector stepping and sweep results.
module tb_p1_sweep_ctrl;

   localparam logic [15:0] EXP = 16'hB2D4;

   typedef struct {
      int          inst;
      logic [15:0] res;
      logic [15:0] fm;
      logic [4:0]  err;
      logic        pass;
      int          e0;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
   logic f0, f1;
   logic [3:0] abcd0, vec0, abcd1, vec1;
   logic busy0, done0, pass0, busy1, done1, pass1;
   logic [15:0] res0, fm0, res1, fm1;
   logic [4:0] err0, err1;

   logic [15:0] ftbl [2];
   int   e0 [2];
   int   nset [2];
   logic prev_done [2];
   exp_t sbq [$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // unit under control modelled directly as a truth-table lookup
   assign f0 = ftbl[0][abcd0];
   assign f1 = ftbl[1][abcd1];

   p1_sweep_ctrl #(.SETTLE_CYCLES(2), .EXPECTED(EXP)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .f_in(f0),
      .abcd(abcd0), .vec_idx(vec0), .busy(busy0), .done(done0), .pass(pass0),
      .result(res0), .fail_mask(fm0), .err_count(err0));

   p1_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(EXP)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f_in(f1),
      .abcd(abcd1), .vec_idx(vec1), .busy(busy1), .done(done1), .pass(pass1),
      .result(res1), .fail_mask(fm1), .err_count(err1));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic mon_inst(input int k, input logic busy, input logic done,
                           input logic [3:0] abcd, input logic [3:0] vec, input logic pass,
                           input logic [15:0] res, input logic [15:0] fm, input logic [4:0] err);
      exp_t e;
      if (busy) begin
         chk("abcd_step", 32'(abcd), 32'((cyc - e0[k]) / nset[k]));
         chk("vec_idx_step", 32'(vec), 32'((cyc - e0[k]) / nset[k]));
      end
      if (done && !prev_done[k]) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("sb_inst", 32'(k), 32'(e.inst));
            chk("done_latency", 32'(cyc - e.e0), 32'(16 * nset[k]));
            chk("result", 32'(res), 32'(e.res));
            chk("fail_mask", 32'(fm), 32'(e.fm));
            chk("err_count", 32'(err), 32'(e.err));
            chk("pass", 32'(pass), 32'(e.pass));
            chk("done_abcd", 32'(abcd), 32'd0);
            chk("done_busy", 32'(busy), 32'd0);
         end
      end
      prev_done[k] = done;
   endtask

   // Monitor: samples both instances on the falling edge
   initial begin
      prev_done[0] = 1'b0;
      prev_done[1] = 1'b0;
      forever begin
         @(negedge clk);
         mon_inst(0, busy0, done0, abcd0, vec0, pass0, res0, fm0, err0);
         mon_inst(1, busy1, done1, abcd1, vec1, pass1, res1, fm1, err1);
      end
   end

   task automatic start_sweep(input int k, input logic [15:0] tbl, input bit push, input bit with_abort);
      exp_t e;
      ftbl[k] = tbl;
      if (push) begin
         e.inst = k;
         e.res  = tbl;
         e.fm   = tbl ^ EXP;
         e.err  = 5'($countones(tbl ^ EXP));
         e.pass = (tbl == EXP);
         e.e0   = cyc + 1;
         sbq.push_back(e);
      end
      e0[k] = cyc + 1;
      if (k == 0) begin
         start0 = 1'b1;
         abort0 = with_abort;
      end else begin
         start1 = 1'b1;
         abort1 = with_abort;
      end
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      abort0 = 1'b0;
      abort1 = 1'b0;
   endtask

   task automatic wait_done(input int k);
      int t = 0;
      while (((k == 0) ? done0 : done1) !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("done_timeout", 32'd1, 32'd0);
   endtask

   task automatic zero_chk(input string tag, input logic [3:0] abcd, input logic [3:0] vec,
                           input logic busy, input logic done, input logic pass,
                           input logic [15:0] res, input logic [15:0] fm, input logic [4:0] err);
      chk({tag, "_abcd"}, 32'(abcd), 32'd0);
      chk({tag, "_vec"}, 32'(vec), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_result"}, 32'(res), 32'd0);
      chk({tag, "_fail"}, 32'(fm), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   // Abort raised on the falling edge after edge E0+a; it takes effect at E0+a+1
   task automatic abort_test(input int a, input logic [15:0] tbl);
      int k;
      logic [15:0] mask;
      start_sweep(0, tbl, 1'b0, 1'b0);
      repeat (a) @(negedge clk);
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      k = a / 2;
      mask = 16'((32'd1 << k) - 32'd1);
      chk("abort_busy", 32'(busy0), 32'd0);
      chk("abort_done", 32'(done0), 32'd0);
      chk("abort_abcd", 32'(abcd0), 32'd0);
      chk("abort_result", 32'(res0), 32'(tbl & mask));
      chk("abort_fail", 32'(fm0), 32'((tbl ^ EXP) & mask));
      chk("abort_err", 32'(err0), 32'($countones((tbl ^ EXP) & mask)));
      repeat (3) @(negedge clk);
      chk("abort_stays_idle", 32'(busy0), 32'd0);
   endtask

   function automatic logic [15:0] rand_tbl();
      case ($urandom_range(0, 3))
         0: return EXP;
         1: return 16'h0000;
         2: return EXP ^ 16'($urandom);
         default: return EXP ^ (16'h0001 << $urandom_range(0, 15));
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nset[0] = 2;
      nset[1] = 1;
      e0[0] = 0;
      e0[1] = 0;
      ftbl[0] = EXP;
      ftbl[1] = EXP;
      repeat (2) @(negedge clk);
      zero_chk("reset0", abcd0, vec0, busy0, done0, pass0, res0, fm0, err0);
      zero_chk("reset1", abcd1, vec1, busy1, done1, pass1, res1, fm1, err1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // correct unit: full pass
      start_sweep(0, EXP, 1'b1, 1'b0);
      wait_done(0);
      // f tied low
      start_sweep(0, 16'h0000, 1'b1, 1'b0);
      wait_done(0);
      // vector 5 inverted: err_count rises at E0+12
      start_sweep(0, EXP ^ 16'h0020, 1'b1, 1'b0);
      repeat (11) @(negedge clk);
      chk("err_before_v5", 32'(err0), 32'd0);
      @(negedge clk);
      chk("err_after_v5", 32'(err0), 32'd1);
      wait_done(0);

      // aborts: after vector 5 applied, on a sampling edge, then random points
      abort_test(10, EXP);
      abort_test(11, 16'hFFFF);
      for (int i = 0; i < 3; i++) abort_test($urandom_range(1, 31), rand_tbl());
      start_sweep(0, EXP, 1'b1, 1'b0);
      wait_done(0);

      // start during RUN is ignored; start in DONE clears and restarts
      start_sweep(0, rand_tbl(), 1'b1, 1'b0);
      repeat (6) @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_done(0);
      start_sweep(0, rand_tbl(), 1'b1, 1'b1);
      chk("restart_done", 32'(done0), 32'd0);
      chk("restart_busy", 32'(busy0), 32'd1);
      chk("restart_result", 32'(res0), 32'd0);
      wait_done(0);

      for (int i = 0; i < 5; i++) begin
         start_sweep(0, rand_tbl(), 1'b1, 1'b0);
         wait_done(0);
      end

      // settle of one cycle
      for (int i = 0; i < 3; i++) begin
         start_sweep(1, (i == 0) ? EXP : rand_tbl(), 1'b1, 1'b0);
         wait_done(1);
      end

      // asynchronous reset while vector 9 is applied
      start_sweep(0, EXP, 1'b0, 1'b0);
      repeat (19) @(negedge clk);
      chk("pre_reset_abcd", 32'(abcd0), 32'd9);
      #1 rst_n = 1'b0;
      #1;
      zero_chk("async0", abcd0, vec0, busy0, done0, pass0, res0, fm0, err0);
      zero_chk("async1", abcd1, vec1, busy1, done1, pass1, res1, fm1, err1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_reset_busy", 32'(busy0), 32'd0);
      chk("post_reset_done", 32'(done0), 32'd0);
      chk("post_reset_abcd", 32'(abcd0), 32'd0);

      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
